// File: rtl/tx_resp_packer.sv
// Packs 16-bit ALU results and 8-bit read data into single-byte TX FIFO writes,
// with one pending slot for back-to-back results and a sticky drop flag.
module tx_resp_packer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OUT_WIDTH  = 2 * DATA_WIDTH,
  parameter bit          MSB_FIRST  = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [OUT_WIDTH-1:0]  ALU_OUT,
  input  logic                  OUT_Valid,
  input  logic [DATA_WIDTH-1:0] RdData,
  input  logic                  RdData_Valid,
  input  logic                  FIFO_FULL,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  BUSY,
  output logic                  OVERFLOW
);

  typedef enum logic [1:0] {
    StIdle,
    StSendB0,
    StGap,
    StSendB1
  } state_e;

  state_e                state_q;
  logic                  act_alu_q;
  logic [OUT_WIDTH-1:0]  act_data_q;
  logic                  pend_vld_q;
  logic                  pend_alu_q;
  logic [OUT_WIDTH-1:0]  pend_data_q;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  tx_vld_q;
  logic                  overflow_q;

  logic                  any_req;
  logic                  both_req;
  logic [OUT_WIDTH-1:0]  rd_ext;
  logic [OUT_WIDTH-1:0]  arr_data;
  logic [DATA_WIDTH-1:0] act_lo;
  logic [DATA_WIDTH-1:0] act_hi;
  logic [DATA_WIDTH-1:0] first_byte;
  logic [DATA_WIDTH-1:0] second_byte;

  assign any_req  = OUT_Valid | RdData_Valid;
  assign both_req = OUT_Valid & RdData_Valid;
  assign rd_ext   = {{(OUT_WIDTH - DATA_WIDTH){1'b0}}, RdData};
  // When both sources fire, the ALU result wins whichever slot is free.
  assign arr_data = OUT_Valid ? ALU_OUT : rd_ext;

  assign act_lo      = act_data_q[DATA_WIDTH-1:0];
  assign act_hi      = act_data_q[OUT_WIDTH-1:DATA_WIDTH];
  assign first_byte  = (act_alu_q && MSB_FIRST) ? act_hi : act_lo;
  assign second_byte = MSB_FIRST ? act_lo : act_hi;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      act_alu_q   <= 1'b0;
      act_data_q  <= '0;
      pend_vld_q  <= 1'b0;
      pend_alu_q  <= 1'b0;
      pend_data_q <= '0;
      tx_data_q   <= '0;
      tx_vld_q    <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      tx_vld_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (pend_vld_q) begin
            // Pending request is promoted; a fresh arrival refills the slot.
            act_alu_q  <= pend_alu_q;
            act_data_q <= pend_data_q;
            state_q    <= StSendB0;
            pend_vld_q <= any_req;
            if (any_req) begin
              pend_alu_q  <= OUT_Valid;
              pend_data_q <= arr_data;
            end
            if (both_req) begin
              overflow_q <= 1'b1;
            end
          end else if (any_req) begin
            act_alu_q  <= OUT_Valid;
            act_data_q <= arr_data;
            state_q    <= StSendB0;
            if (both_req) begin
              pend_vld_q  <= 1'b1;
              pend_alu_q  <= 1'b0;
              pend_data_q <= rd_ext;
            end
          end
        end

        StSendB0: begin
          if (!FIFO_FULL) begin
            tx_vld_q  <= 1'b1;
            tx_data_q <= first_byte;
            state_q   <= act_alu_q ? StGap : StIdle;
          end
        end

        // Idle cycle so the FIFO full flag can reflect the previous push.
        StGap: state_q <= StSendB1;

        StSendB1: begin
          if (!FIFO_FULL) begin
            tx_vld_q  <= 1'b1;
            tx_data_q <= second_byte;
            state_q   <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase

      if (state_q != StIdle && any_req) begin
        if (pend_vld_q || both_req) begin
          overflow_q <= 1'b1;
        end
        if (!pend_vld_q) begin
          pend_vld_q  <= 1'b1;
          pend_alu_q  <= OUT_Valid;
          pend_data_q <= arr_data;
        end
      end
    end
  end

  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;
  assign BUSY      = (state_q != StIdle) || pend_vld_q;
  assign OVERFLOW  = overflow_q;

endmodule

// File: tb/tb_tx_resp_packer.sv
// Self-checking bench for tx_resp_packer: directed scenarios plus randomized
// traffic against a byte-queue reference model.
module tb_tx_resp_packer;

  localparam bit MSB_FIRST = 1'b0;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic        OUT_Valid = 1'b0;
  logic [7:0]  RdData = '0;
  logic        RdData_Valid = 1'b0;
  logic        FIFO_FULL = 1'b0;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        BUSY;
  logic        OVERFLOW;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  tx_resp_packer #(
    .DATA_WIDTH(8),
    .OUT_WIDTH (16),
    .MSB_FIRST (MSB_FIRST)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ALU_OUT     (ALU_OUT),
    .OUT_Valid   (OUT_Valid),
    .RdData      (RdData),
    .RdData_Valid(RdData_Valid),
    .FIFO_FULL   (FIFO_FULL),
    .TX_P_DATA   (TX_P_DATA),
    .TX_D_VLD    (TX_D_VLD),
    .BUSY        (BUSY),
    .OVERFLOW    (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  // Reference model: queued bytes of the active request, a pending request,
  // and the earliest edge at which the next byte may be pushed.
  typedef logic [7:0] bq_t[$];
  bq_t        m_act;
  bq_t        m_pend;
  bit         m_pend_v;
  int         m_ready;
  bit         m_ovf;
  bit         m_vld;
  logic [7:0] m_data;

  function automatic bq_t alu_bytes(input logic [15:0] v);
    bq_t q;
    if (MSB_FIRST) begin
      q.push_back(v[15:8]);
      q.push_back(v[7:0]);
    end else begin
      q.push_back(v[7:0]);
      q.push_back(v[15:8]);
    end
    return q;
  endfunction

  function automatic bq_t rd_bytes(input logic [7:0] v);
    bq_t q;
    q.push_back(v);
    return q;
  endfunction

  task automatic model_reset();
    m_act.delete();
    m_pend.delete();
    m_pend_v = 1'b0;
    m_ready  = 0;
    m_ovf    = 1'b0;
    m_vld    = 1'b0;
    m_data   = 8'h00;
  endtask

  task automatic model_update();
    int  e;
    bit  any_r;
    bit  both_r;
    e      = cyc + 1;
    any_r  = OUT_Valid || RdData_Valid;
    both_r = OUT_Valid && RdData_Valid;
    if (RST) begin
      model_reset();
      return;
    end
    m_vld = 1'b0;
    if (m_act.size() == 0) begin
      if (m_pend_v) begin
        m_act    = m_pend;
        m_pend_v = 1'b0;
        m_ready  = e + 1;
        if (any_r) begin
          if (OUT_Valid) m_pend = alu_bytes(ALU_OUT);
          else           m_pend = rd_bytes(RdData);
          m_pend_v = 1'b1;
          if (both_r) m_ovf = 1'b1;
        end
      end else if (OUT_Valid) begin
        m_act   = alu_bytes(ALU_OUT);
        m_ready = e + 1;
        if (RdData_Valid) begin
          m_pend   = rd_bytes(RdData);
          m_pend_v = 1'b1;
        end
      end else if (RdData_Valid) begin
        m_act   = rd_bytes(RdData);
        m_ready = e + 1;
      end
    end else begin
      if (e >= m_ready && !FIFO_FULL) begin
        m_data  = m_act.pop_front();
        m_vld   = 1'b1;
        m_ready = e + 2;
      end
      if (any_r) begin
        if (m_pend_v || both_r) m_ovf = 1'b1;
        if (!m_pend_v) begin
          if (OUT_Valid) m_pend = alu_bytes(ALU_OUT);
          else           m_pend = rd_bytes(RdData);
          m_pend_v = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    #1 RST = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (TX_D_VLD !== 1'b0 || TX_P_DATA !== 8'h00 || BUSY !== 1'b0 || OVERFLOW !== 1'b0) begin
      n_errors++;
      $display("FAIL reset vld=%b data=%h busy=%b ovf=%b expected 0 00 0 0",
               TX_D_VLD, TX_P_DATA, BUSY, OVERFLOW);
    end
    idle_ticks(2);
    RST = 1'b0;
    idle_ticks(2);
    n_checks++;
    if (TX_D_VLD !== 1'b0 || BUSY !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release vld=%b busy=%b expected 0 0", TX_D_VLD, BUSY);
    end
  endtask

  task automatic test_alu_single();
    bit         ev[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] ed[4] = '{8'h5A, 8'h5A, 8'hA5, 8'hA5};
    ALU_OUT = 16'hA55A;
    OUT_Valid = 1'b1;
    tick();
    OUT_Valid = 1'b0;
    n_checks++;
    if (BUSY !== 1'b1 || TX_D_VLD !== 1'b0) begin
      n_errors++;
      $display("FAIL alu_accept busy=%b vld=%b expected 1 0", BUSY, TX_D_VLD);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (TX_D_VLD !== ev[i] || TX_P_DATA !== ed[i]) begin
        n_errors++;
        $display("FAIL alu_single k+%0d vld=%b data=%h expected vld=%b data=%h",
                 i + 1, TX_D_VLD, TX_P_DATA, ev[i], ed[i]);
      end
    end
    n_checks++;
    if (BUSY !== 1'b0) begin
      n_errors++;
      $display("FAIL alu_done_busy busy=%b expected 0", BUSY);
    end
  endtask

  task automatic test_rd_single();
    RdData = 8'h3C;
    RdData_Valid = 1'b1;
    tick();
    RdData_Valid = 1'b0;
    RdData = 8'hFF;
    tick();
    n_checks++;
    if (TX_D_VLD !== 1'b1 || TX_P_DATA !== 8'h3C || BUSY !== 1'b0 || OVERFLOW !== 1'b0) begin
      n_errors++;
      $display("FAIL rd_single vld=%b data=%h busy=%b ovf=%b expected 1 3c 0 0",
               TX_D_VLD, TX_P_DATA, BUSY, OVERFLOW);
    end
    tick();
    n_checks++;
    if (TX_D_VLD !== 1'b0 || TX_P_DATA !== 8'h3C) begin
      n_errors++;
      $display("FAIL rd_hold vld=%b data=%h expected 0 3c", TX_D_VLD, TX_P_DATA);
    end
  endtask

  task automatic test_both();
    bit         ev[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] ed[6] = '{8'h34, 8'h34, 8'h12, 8'h12, 8'h77, 8'h77};
    ALU_OUT = 16'h1234;
    RdData = 8'h77;
    OUT_Valid = 1'b1;
    RdData_Valid = 1'b1;
    tick();
    OUT_Valid = 1'b0;
    RdData_Valid = 1'b0;
    ALU_OUT = 16'h0000;
    RdData = 8'h00;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (TX_D_VLD !== ev[i] || TX_P_DATA !== ed[i]) begin
        n_errors++;
        $display("FAIL both k+%0d vld=%b data=%h expected vld=%b data=%h",
                 i + 1, TX_D_VLD, TX_P_DATA, ev[i], ed[i]);
      end
    end
    n_checks++;
    if (OVERFLOW !== 1'b0 || BUSY !== 1'b0) begin
      n_errors++;
      $display("FAIL both_end ovf=%b busy=%b expected 0 0", OVERFLOW, BUSY);
    end
  endtask

  task automatic test_full_stall();
    bit         ev[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] ed[4] = '{8'hEF, 8'hEF, 8'hBE, 8'hBE};
    FIFO_FULL = 1'b1;
    ALU_OUT = 16'hBEEF;
    OUT_Valid = 1'b1;
    tick();
    OUT_Valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_checks++;
      if (TX_D_VLD !== 1'b0 || BUSY !== 1'b1) begin
        n_errors++;
        $display("FAIL full_stall k+%0d vld=%b busy=%b expected 0 1", i, TX_D_VLD, BUSY);
      end
    end
    FIFO_FULL = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (TX_D_VLD !== ev[i] || TX_P_DATA !== ed[i]) begin
        n_errors++;
        $display("FAIL full_release k+%0d vld=%b data=%h expected vld=%b data=%h",
                 i + 5, TX_D_VLD, TX_P_DATA, ev[i], ed[i]);
      end
    end
  endtask

  task automatic test_overflow();
    ALU_OUT = 16'h1357;
    OUT_Valid = 1'b1;
    tick();
    OUT_Valid = 1'b0;
    RdData = 8'h01;
    RdData_Valid = 1'b1;
    tick();
    n_checks++;
    if (TX_D_VLD !== 1'b1 || TX_P_DATA !== 8'h57 || OVERFLOW !== 1'b0) begin
      n_errors++;
      $display("FAIL ovf_first vld=%b data=%h ovf=%b expected 1 57 0",
               TX_D_VLD, TX_P_DATA, OVERFLOW);
    end
    RdData = 8'h02;
    tick();
    n_checks++;
    if (TX_D_VLD !== 1'b0 || OVERFLOW !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf_drop vld=%b ovf=%b expected 0 1", TX_D_VLD, OVERFLOW);
    end
    RdData = 8'h03;
    tick();
    RdData_Valid = 1'b0;
    n_checks++;
    if (TX_D_VLD !== 1'b1 || TX_P_DATA !== 8'h13) begin
      n_errors++;
      $display("FAIL ovf_second vld=%b data=%h expected 1 13", TX_D_VLD, TX_P_DATA);
    end
    tick();
    n_checks++;
    if (TX_D_VLD !== 1'b0 || BUSY !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf_promote vld=%b busy=%b expected 0 1", TX_D_VLD, BUSY);
    end
    tick();
    n_checks++;
    if (TX_D_VLD !== 1'b1 || TX_P_DATA !== 8'h01) begin
      n_errors++;
      $display("FAIL ovf_queued vld=%b data=%h expected 1 01", TX_D_VLD, TX_P_DATA);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (TX_D_VLD !== 1'b0 || OVERFLOW !== 1'b1 || BUSY !== 1'b0) begin
        n_errors++;
        $display("FAIL ovf_after +%0d vld=%b ovf=%b busy=%b expected 0 1 0",
                 i, TX_D_VLD, OVERFLOW, BUSY);
      end
    end
  endtask

  task automatic test_reset_midway();
    ALU_OUT = 16'hCAFE;
    OUT_Valid = 1'b1;
    tick();
    OUT_Valid = 1'b0;
    tick();
    n_checks++;
    if (TX_D_VLD !== 1'b1 || TX_P_DATA !== 8'hFE) begin
      n_errors++;
      $display("FAIL midrst_first vld=%b data=%h expected 1 fe", TX_D_VLD, TX_P_DATA);
    end
    RST = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (TX_D_VLD !== 1'b0 || BUSY !== 1'b0 || OVERFLOW !== 1'b0 || TX_P_DATA !== 8'h00) begin
      n_errors++;
      $display("FAIL midrst_async vld=%b busy=%b ovf=%b data=%h expected 0 0 0 00",
               TX_D_VLD, BUSY, OVERFLOW, TX_P_DATA);
    end
    idle_ticks(2);
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (TX_D_VLD !== 1'b0 || BUSY !== 1'b0) begin
        n_errors++;
        $display("FAIL midrst_after +%0d vld=%b busy=%b expected 0 0", i, TX_D_VLD, BUSY);
      end
    end
  endtask

  task automatic test_random();
    int r;
    int pushes = 0;
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 9);
      FIFO_FULL = ($urandom_range(0, 9) < 3);
      ALU_OUT = 16'($urandom);
      RdData = 8'($urandom);
      OUT_Valid = (r < 2);
      RdData_Valid = (r == 2 || r == 3);
      tick();
      if (m_vld) pushes++;
      n_checks++;
      if (TX_D_VLD !== m_vld || TX_P_DATA !== m_data || BUSY !== (m_act.size() != 0 || m_pend_v)
          || OVERFLOW !== m_ovf) begin
        n_errors++;
        $display("FAIL random cyc=%0d vld=%b data=%h busy=%b ovf=%b expected %b %h %b %b",
                 cyc, TX_D_VLD, TX_P_DATA, BUSY, OVERFLOW, m_vld, m_data,
                 (m_act.size() != 0 || m_pend_v), m_ovf);
      end
    end
    OUT_Valid = 1'b0;
    RdData_Valid = 1'b0;
    FIFO_FULL = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if (TX_D_VLD !== m_vld || TX_P_DATA !== m_data) begin
        n_errors++;
        $display("FAIL random_drain cyc=%0d vld=%b data=%h expected %b %h",
                 cyc, TX_D_VLD, TX_P_DATA, m_vld, m_data);
      end
    end
    n_checks++;
    if (BUSY !== 1'b0 || pushes == 0) begin
      n_errors++;
      $display("FAIL random_end busy=%b pushes=%0d expected busy 0 and pushes>0", BUSY, pushes);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_alu_single();
    idle_ticks(2);
    test_rd_single();
    idle_ticks(2);
    test_both();
    idle_ticks(2);
    test_full_stall();
    idle_ticks(2);
    test_overflow();
    idle_ticks(2);
    test_reset_midway();
    idle_ticks(2);
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tx_resp_packer.md
Name: tx_resp_packer

Overview:
Response byte packer between the system controller's result sources and the write side of the TX async FIFO, in the REF_CLK domain. Turns 16-bit ALU results and 8-bit register-file read data into a stream of single-byte FIFO writes. Honours FIFO full and provides one pending slot so results that arrive back-to-back are not lost.

Parameters:
DATA_WIDTH, 8, FIFO byte width and read-data width
OUT_WIDTH, 16, ALU result width; fixed at 2*DATA_WIDTH
MSB_FIRST, 0, 0 = ALU result sent low byte first; 1 = high byte first

Ports:
CLK  in  1  system clock (REF_CLK domain)
RST  in  1  asynchronous, active-high reset
ALU_OUT  in  OUT_WIDTH  ALU result, qualified by OUT_Valid
OUT_Valid  in  1  one-cycle pulse: ALU_OUT valid
RdData  in  DATA_WIDTH  register-file read data, qualified by RdData_Valid
RdData_Valid  in  1  one-cycle pulse: RdData valid
FIFO_FULL  in  1  async FIFO wfull (write domain)
TX_P_DATA  out  DATA_WIDTH  byte to FIFO, registered
TX_D_VLD  out  1  FIFO write increment, registered one-cycle pulse
BUSY  out  1  high when state != IDLE or pending slot occupied
OVERFLOW  out  1  sticky: a request was dropped

Behaviour:
- Reset (RST=1, async): state=IDLE, active and pending slots empty, TX_P_DATA=0, TX_D_VLD=0, OVERFLOW=0. Reset during a transfer aborts it, and any unsent bytes are discarded.
- Request record: {type (ALU/RD), 16-bit payload}. RD requests use only the low byte.
- States: IDLE, SEND_B0, GAP, SEND_B1.
- IDLE, pending slot occupied: at the next edge, the pending request moves to active and state goes to SEND_B0. A request arriving in the same cycle goes to the pending slot.
- IDLE, pending slot empty:
  - A request on OUT_Valid or RdData_Valid loads active and state goes to SEND_B0.
  - If OUT_Valid and RdData_Valid are both high, ALU becomes active and RD goes to pending.
- SEND_B0:
  - If FIFO_FULL=0 at the edge: TX_D_VLD<=1 and TX_P_DATA<=first byte.
  - First byte is the RD byte, or ALU[7:0] (MSB_FIRST=0) or ALU[15:8] (MSB_FIRST=1).
  - Next state is IDLE for RD, GAP for ALU.
  - If FIFO_FULL=1: stay in SEND_B0 with TX_D_VLD<=0, no timeout.
- GAP: one mandatory idle cycle (TX_D_VLD<=0) so wfull can update after a push, then SEND_B1.
- SEND_B1: same full rule as SEND_B0; sends the remaining ALU byte, then IDLE.
- Pushes are never in consecutive cycles. The IDLE cycle provides the gap between requests.
- TX_D_VLD is high only in the cycle after an edge where a push was decided, and is 0 in every other cycle. TX_P_DATA holds its last value when TX_D_VLD=0.
- Latency: request sampled at edge k → first byte TX_D_VLD at edge k+1. Second ALU byte at edge k+3 if FIFO never full.
- Arrivals while state != IDLE:
  - A single request goes to the pending slot if it is empty. Otherwise it is dropped and OVERFLOW<=1.
  - Two simultaneous requests with pending empty: ALU is stored, RD is dropped, OVERFLOW<=1.
  - Two simultaneous requests with pending occupied: both dropped, OVERFLOW<=1.
- OVERFLOW clears only on reset.
- Active and pending payloads are captured at request time; later input changes do not affect them.

Test Plan:
- ALU_OUT=16'hA55A pulse, FIFO_FULL=0, MSB_FIRST=0 → pushes 8'h5A at k+1 and 8'hA5 at k+3; BUSY low from k+4.
- RdData=8'h3C pulse, FIFO_FULL=0 → single push 8'h3C at k+1; state IDLE after; OVERFLOW=0.
- OUT_Valid(16'h1234) and RdData_Valid(8'h77) in same IDLE cycle → pushes 34, 12, then 77. Pushes fall at k+1, k+3, k+5; no drop.
- ALU 16'hBEEF, FIFO_FULL=1 for cycles k..k+4 → no TX_D_VLD until FULL drops. Then EF, one gap cycle, BE.
- During a busy ALU transfer, three RD pulses 8'h01, 8'h02, 8'h03 → 01 queued and sent after the current result. 02 and 03 dropped; OVERFLOW=1 and stays 1 until RST.
- RST asserted midway (after first ALU byte) → TX_D_VLD=0 immediately, second byte never sent, BUSY=0, OVERFLOW=0.
